framing_encoding: RTL and testbench

Transmit-side PHY framing block for an IEEE 802.15.4-style link. It accepts a burst of parallel bytes (PHR followed by the PSDU) and buffers them. It then emits the complete PPDU as a serial bitstream, one bit per clock: preamble, SFD, PHR, PSDU, LSB first. It sits between the MAC byte interface and the downstream bit-level modulator/spreader.

---
 rtl/framing_encoding.sv | 150 +++++++++++++++
 tb/tb_framing_encoding.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/framing_encoding.sv
// Transmit PHY framing: buffers a PHR+PSDU burst and serialises
// preamble, SFD, PHR and PSDU one bit per clock, LSB first.
module framing_encoding (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] phr_psdu_in,
    input  logic       phr_psdu_in_valid,
    output logic       framing_encoding_out,
    output logic       framing_encoding_out_valid
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PHR,
        PSDU
    } state_t;

    localparam logic [7:0] SFD_OCTET = 8'hA7;

    logic [7:0] buffer [128];
    logic [7:0] wr_ptr;
    logic       cap_active;
    logic [6:0] len;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_n;
    logic [6:0] byte_idx, idx_n;
    logic       out_n, vld_n;
    logic       underrun;
    logic [7:0] phr_byte;

    // Buffer storage carries no reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!reset && phr_psdu_in_valid) begin
            if (state == IDLE)
                buffer[0] <= phr_psdu_in;
            else if (cap_active)
                buffer[wr_ptr[6:0]] <= phr_psdu_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 8'd0;
            cap_active <= 1'b0;
            len        <= 7'd0;
        end else if (state == IDLE) begin
            if (phr_psdu_in_valid) begin
                wr_ptr     <= 8'd1;
                len        <= phr_psdu_in[6:0];
                cap_active <= (phr_psdu_in[6:0] != 7'd0);
            end
        end else if (cap_active) begin
            if (phr_psdu_in_valid) begin
                wr_ptr <= wr_ptr + 8'd1;
                if (wr_ptr[6:0] == len)
                    cap_active <= 1'b0;
            end else begin
                cap_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= IDLE;
            bit_cnt                    <= 3'd0;
            byte_idx                   <= 7'd0;
            framing_encoding_out       <= 1'b0;
            framing_encoding_out_valid <= 1'b0;
        end else begin
            state                      <= state_n;
            bit_cnt                    <= bit_n;
            byte_idx                   <= idx_n;
            framing_encoding_out       <= out_n;
            framing_encoding_out_valid <= vld_n;
        end
    end

    // A PSDU byte is missing when its index was never written.
    assign underrun = ({1'b0, byte_idx} >= wr_ptr);
    assign phr_byte = {1'b0, buffer[0][6:0]};

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        idx_n   = byte_idx;
        out_n   = 1'b0;
        vld_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (phr_psdu_in_valid) begin
                    state_n = PRE;
                    bit_n   = 3'd0;
                    idx_n   = 7'd0;
                end
            end
            PRE: begin
                vld_n = 1'b1;
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    idx_n = byte_idx + 7'd1;
                    if (byte_idx == 7'd3) begin
                        state_n = SFD;
                        idx_n   = 7'd0;
                    end
                end
            end
            SFD: begin
                vld_n = 1'b1;
                out_n = SFD_OCTET[bit_cnt];
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    state_n = PHR;
            end
            PHR: begin
                vld_n = 1'b1;
                out_n = phr_byte[bit_cnt];
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (len == 7'd0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = PSDU;
                        idx_n   = 7'd1;
                    end
                end
            end
            PSDU: begin
                if (bit_cnt == 3'd0 && underrun) begin
                    state_n = IDLE;
                end else begin
                    vld_n = 1'b1;
                    out_n = buffer[byte_idx][bit_cnt];
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_idx == len)
                            state_n = IDLE;
                        else
                            idx_n = byte_idx + 7'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_framing_encoding.sv
// Directed bench for framing_encoding: collects the serial stream
// and compares it with hand-built expected PPDU bit sequences.
module tb_framing_encoding;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] phr_psdu_in;
    logic       phr_psdu_in_valid;
    logic       framing_encoding_out;
    logic       framing_encoding_out_valid;

    int errors = 0;
    int checks = 0;

    logic rx[$];
    logic ex[$];
    int   run;
    int   last_run;
    bit   done;
    bit   prev_vld;
    int   stray;

    framing_encoding dut (
        .clk                        (clk),
        .reset                      (reset),
        .phr_psdu_in                (phr_psdu_in),
        .phr_psdu_in_valid          (phr_psdu_in_valid),
        .framing_encoding_out       (framing_encoding_out),
        .framing_encoding_out_valid (framing_encoding_out_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_encoding_out_valid) begin
            rx.push_back(framing_encoding_out);
            run = run + 1;
        end else begin
            if (framing_encoding_out)
                stray = stray + 1;
            if (prev_vld) begin
                done     = 1'b1;
                last_run = run;
            end
        end
        prev_vld = framing_encoding_out_valid;
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_rx();
        rx.delete();
        ex.delete();
        run      = 0;
        last_run = 0;
        done     = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++)
            ex.push_back(b[i]);
    endtask

    task automatic exp_hdr(input logic [7:0] phr);
        for (int i = 0; i < 32; i++)
            ex.push_back(1'b0);
        push_byte(8'hA7);
        push_byte({1'b0, phr[6:0]});
    endtask

    task automatic drive(input logic [7:0] b[$]);
        foreach (b[i]) begin
            @(negedge clk);
            phr_psdu_in       = b[i];
            phr_psdu_in_valid = 1'b1;
        end
        @(negedge clk);
        phr_psdu_in_valid = 1'b0;
        phr_psdu_in       = 8'h00;
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        phr_psdu_in       = b;
        phr_psdu_in_valid = 1'b1;
        @(negedge clk);
        phr_psdu_in_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 3000 && !done; i++)
            @(negedge clk);
        #1;
        check({tag, "_done"}, int'(done), 1);
    endtask

    task automatic cmp_frame(input string tag, input int nbits);
        int mism;
        mism = 0;
        check({tag, "_len"}, rx.size(), nbits);
        check({tag, "_explen"}, ex.size(), nbits);
        for (int i = 0; i < rx.size() && i < ex.size(); i++)
            if (rx[i] !== ex[i])
                mism++;
        check({tag, "_bits"}, mism, 0);
        check({tag, "_run"}, last_run, nbits);
    endtask

    task automatic check_idle(input string tag);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_idle_vld"}, int'(framing_encoding_out_valid), 0);
        check({tag, "_idle_out"}, int'(framing_encoding_out), 0);
    endtask

    initial begin
        stray             = 0;
        prev_vld          = 1'b0;
        reset             = 1'b1;
        phr_psdu_in       = 8'h00;
        phr_psdu_in_valid = 1'b0;
        clear_rx();
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", int'(framing_encoding_out_valid), 0);
        check("rst_out", int'(framing_encoding_out), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // nominal frame, L=7
        clear_rx();
        exp_hdr(8'h07);
        push_byte(8'h03); push_byte(8'h01); push_byte(8'h05);
        push_byte(8'h21); push_byte(8'h43); push_byte(8'h65);
        push_byte(8'h87);
        drive('{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87});
        wait_frame("nom");
        cmp_frame("nom", 104);
        check_idle("nom");

        // zero-length PSDU with latency check
        clear_rx();
        exp_hdr(8'h00);
        @(negedge clk);
        phr_psdu_in       = 8'h00;
        phr_psdu_in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("lat_k_vld", int'(framing_encoding_out_valid), 0);
        @(negedge clk);
        phr_psdu_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("lat_k1_vld", int'(framing_encoding_out_valid), 1);
        check("lat_k1_out", int'(framing_encoding_out), 0);
        wait_frame("zero");
        cmp_frame("zero", 48);
        check_idle("zero");

        // PHR bit 7 set
        clear_rx();
        exp_hdr(8'h82);
        push_byte(8'hAA); push_byte(8'h55);
        drive('{8'h82, 8'hAA, 8'h55});
        wait_frame("b7");
        cmp_frame("b7", 64);
        check_idle("b7");

        // short burst: L=5 but two PSDU bytes
        clear_rx();
        exp_hdr(8'h05);
        push_byte(8'h11); push_byte(8'h22);
        drive('{8'h05, 8'h11, 8'h22});
        wait_frame("under");
        cmp_frame("under", 64);
        check_idle("under");

        // reset during SFD
        clear_rx();
        drive('{8'h03, 8'hAA, 8'hBB, 8'hCC});
        repeat (32) @(negedge clk);
        check("mid_vld_before", int'(framing_encoding_out_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_vld", int'(framing_encoding_out_valid), 0);
        check("mid_rst_out", int'(framing_encoding_out), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_rx();
        exp_hdr(8'h01);
        push_byte(8'hFF);
        drive('{8'h01, 8'hFF});
        wait_frame("post_rst");
        cmp_frame("post_rst", 56);
        check_idle("post_rst");

        // stray valid pulses while busy are ignored
        clear_rx();
        exp_hdr(8'h02);
        push_byte(8'h3C); push_byte(8'hC3);
        drive('{8'h02, 8'h3C, 8'hC3});
        repeat (5) @(negedge clk);
        pulse(8'hFF);
        repeat (10) @(negedge clk);
        pulse(8'h7F);
        repeat (32) @(negedge clk);
        pulse(8'h00);
        wait_frame("busy");
        cmp_frame("busy", 64);
        check_idle("busy");

        // reset and valid together: byte dropped
        clear_rx();
        @(negedge clk);
        reset             = 1'b1;
        phr_psdu_in       = 8'h05;
        phr_psdu_in_valid = 1'b1;
        @(negedge clk);
        reset             = 1'b0;
        phr_psdu_in_valid = 1'b0;
        check_idle("rst_valid");
        check("rst_valid_bits", rx.size(), 0);

        check("stray_out", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
